// File: rtl/unary_adder_sched.sv
// Round-robin scheduler sharing one unary (run-length) adder among NUM_REQ binary requesters.
// Optional macro UNARY_SCHED_CHECK_EN: compare the counted sum against the latched a+b.

module unary_adder_sched #(
   parameter int BIN_BITS = 4,
   parameter int NUM_REQ  = 4,
   parameter int ID_BITS  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*BIN_BITS-1:0]   req_a,
   input  logic [NUM_REQ*BIN_BITS-1:0]   req_b,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic                          add_a,
   output logic                          add_b,
   input  logic                          add_out,
   output logic                          rsp_valid,
   output logic [ID_BITS-1:0]            rsp_id,
   output logic [BIN_BITS:0]             rsp_sum,
   output logic                          rsp_err
);

   localparam int CW = BIN_BITS + 2;
   localparam int SW = BIN_BITS + 1;
   localparam logic [CW-1:0] TIMEOUT_CNT = {2'b10, {BIN_BITS{1'b0}}};
   localparam logic [SW-1:0] SUM_MAX     = '1;

   typedef enum logic [1:0] {IDLE, RUN, GUARD} state_t;

   state_t               state;
   state_t               state_next;
   logic [ID_BITS-1:0]   last;
   logic [ID_BITS-1:0]   id_lat;
   logic [ID_BITS-1:0]   grant_idx;
   logic                 grant_any;
   logic                 handshake;
   int                   arb_idx;
   logic [BIN_BITS-1:0]  a_lat;
   logic [BIN_BITS-1:0]  b_lat;
   logic [BIN_BITS-1:0]  max_lat;
   logic [BIN_BITS-1:0]  sel_a;
   logic [BIN_BITS-1:0]  sel_b;
   logic [CW-1:0]        cnt;
   logic [SW-1:0]        sum;
   logic                 timeout;
   logic                 run_done;
   logic                 tmo_hit;
`ifdef UNARY_SCHED_CHECK_EN
   logic [SW-1:0]        ab_lat;
`endif

   // Rotating-priority search starting just after the last granted requester.
   always_comb begin
      grant_any = 1'b0;
      grant_idx = '0;
      arb_idx   = 0;
      for (int off = 1; off <= NUM_REQ; off++) begin
         arb_idx = (int'(last) + off) % NUM_REQ;
         if (!grant_any && req_valid[arb_idx]) begin
            grant_any = 1'b1;
            grant_idx = ID_BITS'(arb_idx);
         end
      end
   end

   assign handshake = reset_n && (state == IDLE) && grant_any;
   assign sel_a     = req_a[grant_idx*BIN_BITS +: BIN_BITS];
   assign sel_b     = req_b[grant_idx*BIN_BITS +: BIN_BITS];
   assign max_lat   = (a_lat > b_lat) ? a_lat : b_lat;

   always_comb begin
      req_ready = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         req_ready[i] = handshake && (grant_idx == ID_BITS'(i));
      end
   end

   // The run ends once the adder output has dropped after both streams finished.
   always_comb begin
      run_done = !add_out && (cnt >= {2'b00, max_lat});
      tmo_hit  = !run_done && (cnt == TIMEOUT_CNT);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (handshake) state_next = RUN;
         RUN:     if (run_done || tmo_hit) state_next = GUARD;
         GUARD:   state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Streams are registered from the next count value so a and b rise together.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         last    <= ID_BITS'(NUM_REQ - 1);
         id_lat  <= '0;
         a_lat   <= '0;
         b_lat   <= '0;
         cnt     <= '0;
         sum     <= '0;
         timeout <= 1'b0;
         add_a   <= 1'b0;
         add_b   <= 1'b0;
`ifdef UNARY_SCHED_CHECK_EN
         ab_lat  <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (handshake) begin
                  a_lat   <= sel_a;
                  b_lat   <= sel_b;
                  id_lat  <= grant_idx;
                  last    <= grant_idx;
                  cnt     <= '0;
                  sum     <= '0;
                  timeout <= 1'b0;
                  add_a   <= (sel_a != '0);
                  add_b   <= (sel_b != '0);
`ifdef UNARY_SCHED_CHECK_EN
                  ab_lat  <= SW'(sel_a) + SW'(sel_b);
`endif
               end
            end
            RUN: begin
               cnt <= cnt + CW'(1);
               if (add_out && (sum != SUM_MAX)) begin
                  sum <= sum + SW'(1);
               end
               if (run_done || tmo_hit) begin
                  add_a   <= 1'b0;
                  add_b   <= 1'b0;
                  timeout <= tmo_hit;
               end else begin
                  add_a <= ((cnt + CW'(1)) < {2'b00, a_lat});
                  add_b <= ((cnt + CW'(1)) < {2'b00, b_lat});
               end
            end
            default: begin
               add_a <= 1'b0;
               add_b <= 1'b0;
            end
         endcase
      end
   end

   assign rsp_valid = (state == GUARD);
   assign rsp_id    = id_lat;
   assign rsp_sum   = sum;
`ifdef UNARY_SCHED_CHECK_EN
   assign rsp_err   = (state == GUARD) && ((sum != ab_lat) || timeout);
`else
   assign rsp_err   = (state == GUARD) && timeout;
`endif

endmodule

// File: tb/tb_unary_adder_sched.sv
// Self-checking bench for unary_adder_sched with a behavioural unary adder and arithmetic reference.
// Build with UNARY_SCHED_CHECK_EN defined to exercise the sum-check error path.

module tb_unary_adder_sched;

   localparam int BB = 4;
   localparam int NR = 4;
   localparam int IB = 2;

   logic            clk = 1'b0;
   logic            reset_n = 1'b0;
   logic [NR-1:0]   req_valid = '0;
   logic [NR*BB-1:0] req_a = '0;
   logic [NR*BB-1:0] req_b = '0;
   logic [NR-1:0]   req_ready;
   logic            add_a;
   logic            add_b;
   logic            add_out;
   logic            rsp_valid;
   logic [IB-1:0]   rsp_id;
   logic [BB:0]     rsp_sum;
   logic            rsp_err;

   int n_checks = 0;
   int n_fail = 0;
   int cyc = 0;

`ifdef UNARY_SCHED_CHECK_EN
   localparam logic CHECK_ERR = 1'b1;
`else
   localparam logic CHECK_ERR = 1'b0;
`endif

   unary_adder_sched #(.BIN_BITS(BB), .NUM_REQ(NR)) dut (
      .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
      .req_ready(req_ready), .add_a(add_a), .add_b(add_b), .add_out(add_out),
      .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_err(rsp_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Ideal adder: every input '1' is owed one output '1', emitted as early as possible.
   // Mode 1 holds the output high, mode 2 drops it on the third cycle of a run.
   int   pend;
   int   run_idx;
   int   adder_mode = 0;
   int   pend_nxt;
   logic ideal_out;
   assign ideal_out = (pend + int'(add_a) + int'(add_b)) > 0;
   assign add_out = (adder_mode == 1) ? 1'b1 :
                    ((adder_mode == 2 && run_idx == 2) ? 1'b0 : ideal_out);

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pend    <= 0;
         run_idx <= 0;
      end else begin
         pend_nxt = pend + int'(add_a) + int'(add_b) - int'(add_out);
         pend    <= (pend_nxt < 0) ? 0 : pend_nxt;
         run_idx <= ideal_out ? run_idx + 1 : 0;
      end
   end

   task automatic do_reset();
      @(negedge clk);
      reset_n = 1'b0;
      req_valid = '0;
      adder_mode = 0;
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   // Issues one request from a single requester and collects what the DUT does with it.
   task automatic run_txn(input int id, input int a, input int b, input int budget,
                          output bit got_hs, output int hs_cyc, output bit got_rsp,
                          output int rsp_cyc, output int sum, output int rid, output logic err,
                          output int a_hi, output int b_hi, output int a_first, output int b_first);
      logic [BB-1:0] av;
      logic [BB-1:0] bv;
      av = BB'(a);
      bv = BB'(b);
      got_hs = 0; got_rsp = 0; hs_cyc = -1; rsp_cyc = -1; sum = -1; rid = -1; err = 1'bx;
      a_hi = 0; b_hi = 0; a_first = -1; b_first = -1;
      @(negedge clk);
      req_valid[id] = 1'b1;
      req_a[id*BB +: BB] = av;
      req_b[id*BB +: BB] = bv;
      #1;
      for (int i = 0; i < budget; i++) begin
         if (req_ready[id]) begin
            got_hs = 1;
            hs_cyc = cyc;
            break;
         end
         @(negedge clk);
         #1;
      end
      @(negedge clk);
      req_valid[id] = 1'b0;
      req_a[id*BB +: BB] = BB'($urandom);
      req_b[id*BB +: BB] = BB'($urandom);
      #1;
      if (got_hs) begin
         for (int i = 0; i < budget; i++) begin
            if (add_a) begin a_hi++; if (a_first < 0) a_first = cyc; end
            if (add_b) begin b_hi++; if (b_first < 0) b_first = cyc; end
            if (rsp_valid) begin
               got_rsp = 1; rsp_cyc = cyc; sum = int'(rsp_sum); rid = int'(rsp_id); err = rsp_err;
               break;
            end
            @(negedge clk);
            #1;
         end
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      reset_n = 1'b0;
      req_valid = '1;
      #2;
      n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("[TB] FAIL reset_ready got=%b exp=0000", req_ready); end
      n_checks++; if ({add_a, add_b, rsp_valid, rsp_err} !== 4'b0000) begin n_fail++; $display("[TB] FAIL reset_flags got=%b exp=0000", {add_a, add_b, rsp_valid, rsp_err}); end
      n_checks++; if (rsp_id !== 2'd0 || rsp_sum !== 5'd0) begin n_fail++; $display("[TB] FAIL reset_rsp got=%0d/%0d exp=0/0", rsp_id, rsp_sum); end
      @(negedge clk);
      #1;
      n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("[TB] FAIL reset_ready_held got=%b exp=0000", req_ready); end
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("[TB] FAIL reset_first_grant got=%b exp=0001", req_ready); end
      req_valid = '0;
   endtask

   task automatic test_basic();
      bit gh, gr; int hs, rc, s, id, ah, bh, af, bf; logic e;
      run_txn(0, 3, 5, 40, gh, hs, gr, rc, s, id, e, ah, bh, af, bf);
      n_checks++; if (!gh || !gr) begin n_fail++; $display("[TB] FAIL basic_handshake got=%0d%0d exp=11", gh, gr); end
      n_checks++; if (rc - hs !== 10) begin n_fail++; $display("[TB] FAIL basic_latency got=%0d exp=10", rc - hs); end
      n_checks++; if (s !== 8 || id !== 0 || e !== 1'b0) begin n_fail++; $display("[TB] FAIL basic_rsp got=%0d/%0d/%b exp=8/0/0", s, id, e); end
      n_checks++; if (ah !== 3 || bh !== 5) begin n_fail++; $display("[TB] FAIL basic_stream_len got=%0d/%0d exp=3/5", ah, bh); end
      n_checks++; if (af !== hs + 1 || bf !== hs + 1) begin n_fail++; $display("[TB] FAIL basic_stream_start got=%0d/%0d exp=%0d", af - hs, bf - hs, 1); end
   endtask

   task automatic test_zero_max();
      bit gh, gr; int hs, rc, s, id, ah, bh, af, bf; logic e;
      run_txn(2, 0, 0, 40, gh, hs, gr, rc, s, id, e, ah, bh, af, bf);
      n_checks++; if (!gr || rc - hs !== 2) begin n_fail++; $display("[TB] FAIL zero_latency got=%0d exp=2", rc - hs); end
      n_checks++; if (s !== 0 || id !== 2 || e !== 1'b0 || ah !== 0 || bh !== 0) begin n_fail++; $display("[TB] FAIL zero_rsp got=%0d/%0d/%b/%0d/%0d exp=0/2/0/0/0", s, id, e, ah, bh); end
      run_txn(1, 15, 15, 60, gh, hs, gr, rc, s, id, e, ah, bh, af, bf);
      n_checks++; if (!gr || rc - hs !== 32) begin n_fail++; $display("[TB] FAIL max_latency got=%0d exp=32", rc - hs); end
      n_checks++; if (s !== 30 || id !== 1 || e !== 1'b0) begin n_fail++; $display("[TB] FAIL max_rsp got=%0d/%0d/%b exp=30/1/0", s, id, e); end
   endtask

   task automatic test_round_robin();
      int g_id[5]; int g_cyc[5]; int r_id[5]; int r_cyc[5]; int r_sum[5];
      int ng, nr, gi;
      ng = 0; nr = 0;
      do_reset();
      @(negedge clk);
      req_valid = '1;
      req_a = {4{4'd1}};
      req_b = {4{4'd1}};
      #1;
      for (int i = 0; i < 60 && nr < 5; i++) begin
         if (req_ready !== 4'b0000 && ng < 5) begin
            n_checks++; if (!$onehot(req_ready)) begin n_fail++; $display("[TB] FAIL rr_onehot got=%b exp=one-hot", req_ready); end
            gi = -1;
            for (int k = 0; k < NR; k++) if (req_ready[k] === 1'b1 && gi < 0) gi = k;
            g_id[ng] = gi; g_cyc[ng] = cyc; ng++;
         end
         if (rsp_valid && nr < 5) begin
            r_id[nr] = int'(rsp_id); r_cyc[nr] = cyc; r_sum[nr] = int'(rsp_sum); nr++;
         end
         @(negedge clk);
         if (ng >= 5) req_valid = '0;
         #1;
      end
      req_valid = '0;
      n_checks++; if (ng !== 5 || nr !== 5) begin n_fail++; $display("[TB] FAIL rr_count got=%0d/%0d exp=5/5", ng, nr); end
      for (int k = 0; k < ng && k < nr; k++) begin
         n_checks++; if (g_id[k] !== k % NR) begin n_fail++; $display("[TB] FAIL rr_grant_%0d got=%0d exp=%0d", k, g_id[k], k % NR); end
         n_checks++; if (r_id[k] !== k % NR || r_sum[k] !== 2) begin n_fail++; $display("[TB] FAIL rr_rsp_%0d got=%0d/%0d exp=%0d/2", k, r_id[k], r_sum[k], k % NR); end
         n_checks++; if (r_cyc[k] - g_cyc[0] !== 4 + 5 * k) begin n_fail++; $display("[TB] FAIL rr_timing_%0d got=%0d exp=%0d", k, r_cyc[k] - g_cyc[0], 4 + 5 * k); end
      end
   endtask

   task automatic test_random();
      int ml, mask, g, ea, eb, hs, rc, idx;
      logic [NR-1:0] er;
      bit got;
      do_reset();
      ml = NR - 1;
      for (int t = 0; t < 24; t++) begin
         mask = $urandom_range(1, 15);
         @(negedge clk);
         req_valid = mask[NR-1:0];
         req_a = NR*BB'($urandom);
         req_b = NR*BB'($urandom);
         g = -1;
         for (int off = 1; off <= NR; off++) begin
            idx = (ml + off) % NR;
            if (g < 0 && mask[idx]) g = idx;
         end
         ea = int'(req_a[g*BB +: BB]);
         eb = int'(req_b[g*BB +: BB]);
         er = '0;
         er[g] = 1'b1;
         #1;
         n_checks++; if (req_ready !== er) begin n_fail++; $display("[TB] FAIL rand_grant_%0d got=%b exp=%b", t, req_ready, er); end
         hs = cyc;
         @(negedge clk);
         req_valid = '0;
         req_a = NR*BB'($urandom);
         req_b = NR*BB'($urandom);
         #1;
         got = 0; rc = -1;
         for (int i = 0; i < 50; i++) begin
            if (rsp_valid) begin got = 1; rc = cyc; break; end
            @(negedge clk);
            #1;
         end
         n_checks++; if (!got || rc - hs !== ea + eb + 2) begin n_fail++; $display("[TB] FAIL rand_latency_%0d got=%0d exp=%0d", t, rc - hs, ea + eb + 2); end
         n_checks++; if (int'(rsp_sum) !== ea + eb || int'(rsp_id) !== g || rsp_err !== 1'b0) begin n_fail++; $display("[TB] FAIL rand_rsp_%0d got=%0d/%0d/%b exp=%0d/%0d/0", t, rsp_sum, rsp_id, rsp_err, ea + eb, g); end
         ml = g;
      end
   endtask

   task automatic test_timeout();
      bit gh, gr; int hs, rc, s, id, ah, bh, af, bf; logic e;
      adder_mode = 1;
      run_txn(1, 3, 2, 60, gh, hs, gr, rc, s, id, e, ah, bh, af, bf);
      adder_mode = 0;
      n_checks++; if (!gr || rc - hs !== 34) begin n_fail++; $display("[TB] FAIL timeout_latency got=%0d exp=34", rc - hs); end
      n_checks++; if (s !== 31 || id !== 1 || e !== 1'b1) begin n_fail++; $display("[TB] FAIL timeout_rsp got=%0d/%0d/%b exp=31/1/1", s, id, e); end
      run_txn(1, 2, 3, 40, gh, hs, gr, rc, s, id, e, ah, bh, af, bf);
      n_checks++; if (!gr || rc - hs !== 7 || s !== 5 || e !== 1'b0) begin n_fail++; $display("[TB] FAIL after_timeout got=%0d/%0d/%b exp=7/5/0", rc - hs, s, e); end
   endtask

   task automatic test_check();
      bit gh, gr; int hs, rc, s, id, ah, bh, af, bf; logic e;
      adder_mode = 2;
      run_txn(3, 2, 2, 40, gh, hs, gr, rc, s, id, e, ah, bh, af, bf);
      adder_mode = 0;
      n_checks++; if (!gr || rc - hs !== 4) begin n_fail++; $display("[TB] FAIL drop_latency got=%0d exp=4", rc - hs); end
      n_checks++; if (s !== 2 || id !== 3 || e !== CHECK_ERR) begin n_fail++; $display("[TB] FAIL drop_rsp got=%0d/%0d/%b exp=2/3/%b", s, id, e, CHECK_ERR); end
      repeat (8) @(negedge clk);
   endtask

   task automatic test_reset_mid_run();
      bit gh, gr, seen; int hs, rc, s, id, ah, bh, af, bf; logic e;
      gh = 0;
      @(negedge clk);
      req_valid[2] = 1'b1;
      req_a[2*BB +: BB] = 4'd7;
      req_b[2*BB +: BB] = 4'd6;
      #1;
      for (int i = 0; i < 10; i++) begin
         if (req_ready[2]) begin gh = 1; break; end
         @(negedge clk);
         #1;
      end
      n_checks++; if (!gh) begin n_fail++; $display("[TB] FAIL midrst_handshake got=0 exp=1"); end
      @(negedge clk);
      req_valid[2] = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      n_checks++; if ({add_a, add_b} !== 2'b11) begin n_fail++; $display("[TB] FAIL midrst_running got=%b exp=11", {add_a, add_b}); end
      #1;
      reset_n = 1'b0;
      #1;
      n_checks++; if ({add_a, add_b, rsp_valid} !== 3'b000) begin n_fail++; $display("[TB] FAIL midrst_async got=%b exp=000", {add_a, add_b, rsp_valid}); end
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         #1;
         if (rsp_valid) seen = 1;
      end
      n_checks++; if (seen !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_no_rsp got=1 exp=0"); end
      run_txn(2, 4, 9, 40, gh, hs, gr, rc, s, id, e, ah, bh, af, bf);
      n_checks++; if (!gr || rc - hs !== 15 || s !== 13 || id !== 2 || e !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_next got=%0d/%0d/%0d/%b exp=15/13/2/0", rc - hs, s, id, e); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_zero_max();
      test_round_robin();
      test_random();
      test_timeout();
      test_check();
      test_reset_mid_run();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog got=timeout exp=finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/unary_adder_sched.md
# unary_adder_sched

Round-robin scheduler that shares one `unary_adder` instance between `NUM_REQ` binary requesters. It accepts binary operand pairs, converts each pair into aligned unary (run-length) streams on the adder's `a`/`b` inputs, and counts the adder's `out` run to rebuild a binary sum. It enforces the adder's rule that no new operands start until its output has gone low. It sits between the requesting datapath blocks and the adder, and is the only driver of the adder's inputs.

## Interface
- `BIN_BITS`, 4: operand width; must match the adder's `BIN_BITS`.
- `NUM_REQ`, 4: number of requesters, 1..16.
- `ID_BITS`, `$clog2(NUM_REQ)` (min 1): width of the requester index.
- `clk` input 1: clock; the block uses this one clock only.
- `reset_n` input 1: asynchronous, active-low reset.
- `req_valid` input NUM_REQ: per-requester operand-valid flag.
- `req_a` input NUM_REQ*BIN_BITS: packed operand a; requester i uses bits [i*BIN_BITS +: BIN_BITS].
- `req_b` input NUM_REQ*BIN_BITS: packed operand b, packed the same way.
- `req_ready` output NUM_REQ: one-hot grant; a transfer happens when `req_valid[i]` and `req_ready[i]` are both high.
- `add_a` output 1: unary stream to the adder's `a` input.
- `add_b` output 1: unary stream to the adder's `b` input.
- `add_out` input 1: the adder's `out`.
- `rsp_valid` output 1: one-cycle result strobe; there is no backpressure.
- `rsp_id` output ID_BITS: index of the requester the result belongs to.
- `rsp_sum` output BIN_BITS+1: binary sum.
- `rsp_err` output 1: sum-check or timeout flag.

## Operation
- FSM states: IDLE, RUN, GUARD.
- **IDLE**
  - `req_ready` is combinational: the first requester with `req_valid` high, searching from `last+1` with wrap-around.
  - On handshake: latch a, b and id; set `last` to the granted index; clear `cnt` and `sum`; go to RUN.
  - With no valid request, stay in IDLE.
- **RUN**
  - `add_a = (cnt < a_lat)` and `add_b = (cnt < b_lat)`, both registered off `cnt`, so the two streams start in the same cycle.
  - `cnt` increments every cycle.
  - `sum` increments in each cycle where `add_out == 1`.
  - Go to GUARD on the first cycle where `add_out == 0` and `cnt >= max(a_lat, b_lat)`.
  - Timeout: if `cnt` reaches `2^(BIN_BITS+1)`, go to GUARD and set the error flag.
- **GUARD**
  - Exactly one cycle with `add_a = add_b = 0`, so the adder drains and settles.
  - `rsp_valid = 1`, with `rsp_id`, `rsp_sum` and `rsp_err` valid only in this cycle.
  - Next state is IDLE; no grant is issued during GUARD.
- Width rules:
  - The maximum sum, `2*(2^BIN_BITS - 1)`, fits in BIN_BITS+1 bits.
  - `cnt` is BIN_BITS+2 bits wide, so the timeout value is representable.
  - `sum` saturates at its maximum value and does not wrap.
- Zero operands: a = b = 0 gives one RUN cycle (`add_out` low, `cnt` = 0), then GUARD with `rsp_sum = 0`.
- Fairness: a requester holding `req_valid` high is granted within NUM_REQ transactions.
- `req_a`/`req_b` are sampled only on the handshake cycle; they may change freely afterwards.

## Timing
- Reset values: state = IDLE; `last = NUM_REQ-1`, so requester 0 wins first; `add_a`, `add_b`, `rsp_valid`, `rsp_err` = 0; `rsp_id` = 0; `rsp_sum` = 0; `req_ready` = 0 while `reset_n` is low.
- With the handshake in cycle T, the streams start at T+1.
  - RUN lasts `max(a+b, max(a,b)) + 1` cycles, which is a+b+1 for a correct adder.
  - `rsp_valid` is asserted at T+a+b+2.
- Next grant can occur at T+a+b+3 at the earliest; the back-to-back issue interval is a+b+3 cycles.
- Reset asserted mid-operation: the FSM returns to IDLE immediately and the latched operation is discarded with no response. The adder is reset by the same `reset_n`.

## Configuration
- `UNARY_SCHED_CHECK_EN` defined:
  - Latch `a+b` at handshake.
  - In GUARD, `rsp_err = (sum != a+b) | timeout`.
- `UNARY_SCHED_CHECK_EN` undefined:
  - The reference sum is not stored.
  - `rsp_err = timeout` only.

## Test plan
- Reset, then requester 0 sends a=3, b=5 with an ideal adder model → `add_a` high 3 cycles and `add_b` high 5 cycles, both starting at T+1; `rsp_valid` at T+10 with `rsp_sum = 8`, `rsp_id = 0`, `rsp_err = 0`.
- a=0, b=0 → `rsp_valid` at T+2, `rsp_sum = 0`; then a=15, b=15 → `rsp_sum = 30`, no timeout.
- All 4 requesters hold valid with a=1, b=1 → grants in order 0,1,2,3,0; each response at a 5-cycle spacing; `rsp_id` follows the grant order.
- `add_out` forced high permanently → timeout at `cnt = 32`; `rsp_err = 1` and the FSM returns to IDLE.
- With `UNARY_SCHED_CHECK_EN`, a=2, b=2 and `add_out` dropped for one cycle mid-run → `rsp_sum = 2`, `rsp_err = 1`.
- `reset_n` pulsed low during RUN of a=7, b=6 → no `rsp_valid`; `add_a`/`add_b` go low asynchronously; the next request completes correctly.
